// File: rtl/video_arb_port_pkg.sv
// Shared definitions for the video fetch port arbiter: bandwidth encodings,
// owner tag values and the per-slot grant decision type.
package video_arb_port_pkg;

    // video_bw encodings: fraction of DRAM slots video may claim
    localparam logic [1:0] BW_1_8 = 2'b00;
    localparam logic [1:0] BW_1_4 = 2'b01;
    localparam logic [1:0] BW_1_2 = 2'b10;
    localparam logic [1:0] BW_1_1 = 2'b11;

    // Owner tags stored per in-flight read
    localparam logic OWN_CPU   = 1'b0;
    localparam logic OWN_VIDEO = 1'b1;

    // Outcome of one DRAM slot decision
    typedef enum logic [1:0] {
        GNT_NONE  = 2'b00,
        GNT_CPU   = 2'b01,
        GNT_VIDEO = 2'b10
    } grant_e;

endpackage

// File: rtl/video_arb_tagfifo.sv
// Owner-tag FIFO: one bit per in-flight DRAM read, popped in request order.
// Simultaneous push and pop leave the occupancy unchanged.
module video_arb_tagfifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage
    // NOTE: storage is not reset; empty pointers guarantee stale bits are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/video_arb_port.sv
// Video fetch port arbiter: grants DRAM slots to video by requested
// bandwidth, gives leftover slots to the CPU, and routes read data back to
// the owner of each in-flight read.
// Build option VIDEO_FREE_SLOT_EN: otherwise-idle slots go to video when
// video_go is set, so video may exceed its video_bw share.
module video_arb_port
    import video_arb_port_pkg::*;
#(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cycle_start,
    input  logic              video_go,
    input  logic [1:0]        video_bw,
    input  logic [ADDR_W-1:0] video_addr,
    output logic              video_next,
    output logic              video_strobe,
    output logic [DATA_W-1:0] video_data,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_next,
    output logic              cpu_strobe,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dram_req,
    output logic [ADDR_W-1:0] dram_addr,
    input  logic              dram_rrdy,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              proto_err
);

    logic [2:0] slot_cnt;
    logic       eligible;
    grant_e     grant;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       pop;

    assign pop = dram_rrdy & ~fifo_empty;

    // Is the current slot one that video's bandwidth setting entitles it to
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        eligible = 1'b0;
        case (video_bw)
            BW_1_8:  eligible = (slot_cnt == 3'd0);
            BW_1_4:  eligible = (slot_cnt[1:0] == 2'd0);
            BW_1_2:  eligible = ~slot_cnt[0];
            default: eligible = 1'b1;
        endcase
    end

    // Slot decision: a full owner FIFO blocks everything, then video, then CPU
    always_comb begin
        grant = GNT_NONE;
        if (cycle_start && !fifo_full) begin
            if (video_go && eligible) begin
                grant = GNT_VIDEO;
            end else if (cpu_req) begin
                grant = GNT_CPU;
            end
`ifdef VIDEO_FREE_SLOT_EN
            else if (video_go) begin
                grant = GNT_VIDEO;
            end
`endif
        end
    end

    // Slot counter advances on every decision point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_cnt <= '0;
        else if (cycle_start) slot_cnt <= slot_cnt + 3'd1;
    end

    // Registered grant: DRAM request, address and the winner's next pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_req   <= 1'b0;
            dram_addr  <= '0;
            video_next <= 1'b0;
            cpu_next   <= 1'b0;
        end else begin
            dram_req   <= (grant != GNT_NONE);
            video_next <= (grant == GNT_VIDEO);
            cpu_next   <= (grant == GNT_CPU);
            if (grant == GNT_VIDEO)    dram_addr <= video_addr;
            else if (grant == GNT_CPU) dram_addr <= cpu_addr;
        end
    end

    // Read return: steer data to the owner at the FIFO head, flag orphan returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_strobe <= 1'b0;
            cpu_strobe   <= 1'b0;
            video_data   <= '0;
            cpu_rdata    <= '0;
            proto_err    <= 1'b0;
        end else begin
            video_strobe <= pop & (fifo_head == OWN_VIDEO);
            cpu_strobe   <= pop & (fifo_head == OWN_CPU);
            if (pop && fifo_head == OWN_VIDEO) video_data <= dram_rdata;
            if (pop && fifo_head == OWN_CPU)   cpu_rdata  <= dram_rdata;
            if (dram_rrdy && fifo_empty)       proto_err  <= 1'b1;
        end
    end

    video_arb_tagfifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tagfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant != GNT_NONE),
        .din   ((grant == GNT_VIDEO) ? OWN_VIDEO : OWN_CPU),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_video_arb_port.sv
// Directed bench for video_arb_port: slot allocation by bandwidth, CPU
// fill-in, read return ordering, FIFO-full blocking, orphan returns, reset.
module tb_video_arb_port;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cycle_start;
    logic              video_go;
    logic [1:0]        video_bw;
    logic [ADDR_W-1:0] video_addr;
    logic              video_next;
    logic              video_strobe;
    logic [DATA_W-1:0] video_data;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_next;
    logic              cpu_strobe;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dram_req;
    logic [ADDR_W-1:0] dram_addr;
    logic              dram_rrdy;
    logic [DATA_W-1:0] dram_rdata;
    logic              proto_err;

    int checks   = 0;
    int failures = 0;
    int n_slot   = 0;

    // Values captured one clk after a slot decision / a read return
    logic              s_vnext, s_cnext, s_req, s_vstb, s_cstb;
    logic [ADDR_W-1:0] s_addr, exp_vaddr, exp_caddr;
    logic [DATA_W-1:0] s_vdata;
    logic              r_vstb, r_cstb, r_perr;
    logic [DATA_W-1:0] r_vdata, r_cdata;

    video_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cycle_start  (cycle_start),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .video_addr   (video_addr),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_next     (cpu_next),
        .cpu_strobe   (cpu_strobe),
        .cpu_rdata    (cpu_rdata),
        .dram_req     (dram_req),
        .dram_addr    (dram_addr),
        .dram_rrdy    (dram_rrdy),
        .dram_rdata   (dram_rdata),
        .proto_err    (proto_err)
    );

    always #18 clk = ~clk;

    // One DRAM slot: cycle_start for one clk, then one quiet clk
    task automatic slot(input logic go, input logic [1:0] bw, input logic cr,
                        input logic rr, input logic [DATA_W-1:0] rd);
        video_go    = go;
        video_bw    = bw;
        cpu_req     = cr;
        video_addr  = 21'h1A0000 + 21'(n_slot);
        cpu_addr    = 21'h0C0000 + 21'(n_slot);
        exp_vaddr   = video_addr;
        exp_caddr   = cpu_addr;
        dram_rrdy   = rr;
        dram_rdata  = rd;
        cycle_start = 1'b1;
        @(negedge clk);
        cycle_start = 1'b0;
        dram_rrdy   = 1'b0;
        video_go    = 1'b0;
        cpu_req     = 1'b0;
        s_vnext = video_next;
        s_cnext = cpu_next;
        s_req   = dram_req;
        s_addr  = dram_addr;
        s_vstb  = video_strobe;
        s_cstb  = cpu_strobe;
        s_vdata = video_data;
        n_slot++;
        @(negedge clk);
    endtask

    // One DRAM read return outside any decision clk
    task automatic ret(input logic [DATA_W-1:0] d);
        dram_rrdy  = 1'b1;
        dram_rdata = d;
        @(negedge clk);
        dram_rrdy = 1'b0;
        r_vstb  = video_strobe;
        r_cstb  = cpu_strobe;
        r_vdata = video_data;
        r_cdata = cpu_rdata;
        r_perr  = proto_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cycle_start = 1'b0; video_go = 1'b0; video_bw = 2'b00;
        video_addr = '0; cpu_req = 1'b0; cpu_addr = '0; dram_rrdy = 1'b0; dram_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({video_next, video_strobe, video_data, cpu_next, cpu_strobe, cpu_rdata,
             dram_req, dram_addr, proto_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero (req=%b addr=%h perr=%b), want all 0",
                     dram_req, dram_addr, proto_err);
        end
        rst_n  = 1'b1;
        n_slot = 0;
        @(negedge clk);
    endtask

    task automatic test_bw_1_8();
        int vcount;
        int idx[2];
        vcount = 0;
        idx[0] = -1; idx[1] = -1;
        for (int i = 0; i < 16; i++) begin
            slot(1'b1, 2'b00, 1'b0, 1'b0, '0);
            if (s_vnext) begin
                if (vcount < 2) idx[vcount] = i;
                vcount++;
                ret(16'h5000 + 16'(i));
                checks++;
                if (r_vstb !== 1'b1 || r_vdata !== 16'h5000 + 16'(i)) begin
                    failures++;
                    $display("FAIL bw18_return slot %0d: strobe=%b data=%h, want 1 %h",
                             i, r_vstb, r_vdata, 16'h5000 + 16'(i));
                end
            end
        end
`ifdef VIDEO_FREE_SLOT_EN
        checks++;
        if (vcount != 16) begin
            failures++;
            $display("FAIL bw18_count: video_next=%0d, want 16", vcount);
        end
`else
        checks++;
        if (vcount != 2) begin
            failures++;
            $display("FAIL bw18_count: video_next=%0d, want 2", vcount);
        end
        checks++;
        if (idx[0] != 0 || idx[1] != 8) begin
            failures++;
            $display("FAIL bw18_slots: grants at %0d,%0d, want 0,8", idx[0], idx[1]);
        end
`endif
    endtask

    task automatic test_bw_1_4_cpu();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            exp_v = (i % 4 == 0);
            slot(1'b1, 2'b01, 1'b1, 1'b0, '0);
            checks++;
            if ({s_vnext, s_cnext, s_req} !== {exp_v, ~exp_v, 1'b1}) begin
                failures++;
                $display("FAIL bw14_grant slot %0d: vnext/cnext/req=%b%b%b, want %b%b1",
                         i, s_vnext, s_cnext, s_req, exp_v, ~exp_v);
            end
            checks++;
            if (s_addr !== (exp_v ? exp_vaddr : exp_caddr)) begin
                failures++;
                $display("FAIL bw14_addr slot %0d: dram_addr=%h, want %h",
                         i, s_addr, exp_v ? exp_vaddr : exp_caddr);
            end
            ret(16'h6000 + 16'(i));
            checks++;
            if ({r_vstb, r_cstb} !== {exp_v, ~exp_v} ||
                (exp_v ? r_vdata : r_cdata) !== 16'h6000 + 16'(i)) begin
                failures++;
                $display("FAIL bw14_return slot %0d: vstb=%b cstb=%b, want %b%b data %h",
                         i, r_vstb, r_cstb, exp_v, ~exp_v, 16'h6000 + 16'(i));
            end
        end
    endtask

    task automatic test_return_order();
        slot(1'b1, 2'b11, 1'b1, 1'b0, '0);
        slot(1'b0, 2'b11, 1'b1, 1'b0, '0);
        checks++;
        if ({s_vnext, s_cnext} !== 2'b01) begin
            failures++;
            $display("FAIL order_cpu_grant: vnext/cnext=%b%b, want 01", s_vnext, s_cnext);
        end
        slot(1'b1, 2'b11, 1'b0, 1'b0, '0);
        ret(16'h1111);
        checks++;
        if ({r_vstb, r_cstb} !== 2'b10 || r_vdata !== 16'h1111) begin
            failures++;
            $display("FAIL order_1: vstb=%b cstb=%b vdata=%h, want 10 1111", r_vstb, r_cstb, r_vdata);
        end
        ret(16'h2222);
        checks++;
        if ({r_vstb, r_cstb} !== 2'b01 || r_cdata !== 16'h2222) begin
            failures++;
            $display("FAIL order_2: vstb=%b cstb=%b cdata=%h, want 01 2222", r_vstb, r_cstb, r_cdata);
        end
        ret(16'h3333);
        checks++;
        if ({r_vstb, r_cstb} !== 2'b10 || r_vdata !== 16'h3333 || r_cdata !== 16'h2222) begin
            failures++;
            $display("FAIL order_3: vstb=%b cstb=%b vdata=%h cdata=%h, want 10 3333 2222",
                     r_vstb, r_cstb, r_vdata, r_cdata);
        end
        @(negedge clk);
        checks++;
        if (video_strobe !== 1'b0 || cpu_strobe !== 1'b0) begin
            failures++;
            $display("FAIL order_pulse_width: vstb=%b cstb=%b after return, want 00", video_strobe, cpu_strobe);
        end
    endtask

    task automatic test_fifo_full();
        int reqs;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            slot(1'b1, 2'b11, 1'b0, 1'b0, '0);
            if (s_req) reqs++;
        end
        checks++;
        if (reqs != 4 || s_req !== 1'b0) begin
            failures++;
            $display("FAIL full_block: grants=%0d last_req=%b, want 4 0", reqs, s_req);
        end
        ret(16'hA001);
        checks++;
        if (r_vstb !== 1'b1 || r_vdata !== 16'hA001) begin
            failures++;
            $display("FAIL full_pop: vstb=%b data=%h, want 1 A001", r_vstb, r_vdata);
        end
        // occupancy 3: grant and return in the same clk keep it at 3
        slot(1'b1, 2'b11, 1'b0, 1'b1, 16'hA002);
        checks++;
        if (s_req !== 1'b1 || s_vstb !== 1'b1 || s_vdata !== 16'hA002) begin
            failures++;
            $display("FAIL push_pop: req=%b vstb=%b data=%h, want 1 1 A002", s_req, s_vstb, s_vdata);
        end
        slot(1'b1, 2'b11, 1'b0, 1'b0, '0);
        checks++;
        if (s_req !== 1'b1) begin
            failures++;
            $display("FAIL refill: req=%b, want 1", s_req);
        end
        slot(1'b1, 2'b11, 1'b0, 1'b0, '0);
        checks++;
        if (s_req !== 1'b0) begin
            failures++;
            $display("FAIL full_again: req=%b, want 0", s_req);
        end
        for (int i = 0; i < 4; i++) begin
            ret(16'hB000 + 16'(i));
            checks++;
            if (r_vstb !== 1'b1 || r_vdata !== 16'hB000 + 16'(i) || r_perr !== 1'b0) begin
                failures++;
                $display("FAIL drain_%0d: vstb=%b data=%h perr=%b, want 1 %h 0",
                         i, r_vstb, r_vdata, r_perr, 16'hB000 + 16'(i));
            end
        end
    endtask

    task automatic test_proto_err();
        ret(16'hDEAD);
        checks++;
        if (r_perr !== 1'b1 || r_vstb !== 1'b0 || r_cstb !== 1'b0 ||
            r_vdata !== '0 || r_cdata !== '0) begin
            failures++;
            $display("FAIL orphan_rrdy: perr=%b vstb=%b cstb=%b vdata=%h cdata=%h, want 1 0 0 0 0",
                     r_perr, r_vstb, r_cstb, r_vdata, r_cdata);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL proto_err_sticky: perr=%b, want 1", proto_err);
        end
    endtask

    task automatic test_reset_inflight();
        slot(1'b1, 2'b11, 1'b0, 1'b0, '0);
        video_go = 1'b1; video_bw = 2'b11;
        cycle_start = 1'b1;
        @(negedge clk);
        cycle_start = 1'b0; video_go = 1'b0;
        checks++;
        if (dram_req !== 1'b1 || video_next !== 1'b1) begin
            failures++;
            $display("FAIL inflight_grant: req=%b vnext=%b, want 1 1", dram_req, video_next);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dram_req, dram_addr, video_next, cpu_next, video_strobe, cpu_strobe, proto_err} !== '0) begin
            failures++;
            $display("FAIL async_reset: req=%b addr=%h vnext=%b, want all 0", dram_req, dram_addr, video_next);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ret(16'hC000 + 16'(i));
            checks++;
            if (r_perr !== 1'b1 || r_vstb !== 1'b0 || r_cstb !== 1'b0) begin
                failures++;
                $display("FAIL late_rrdy_%0d: perr=%b vstb=%b cstb=%b, want 1 0 0", i, r_perr, r_vstb, r_cstb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bw_1_8();
        test_reset();
        test_bw_1_4_cpu();
        test_reset();
        test_return_order();
        test_reset();
        test_fifo_full();
        test_reset();
        test_proto_err();
        test_reset();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
